// File: rtl/pmbist_scan_driver_if.sv
// Host command/result bus and pmbist serial access port of the scan driver.
// slave = the driver itself, master = host plus the pmbist_top side of the chain.
interface pmbist_scan_driver_if #(
  parameter int MAX_LEN = 512,
  parameter int LEN_W   = 10,
  parameter int RUN_W   = 16
);
  logic               start;
  logic [LEN_W-1:0]   len;
  logic               do_update;
  logic [RUN_W-1:0]   run_cycles;
  logic [MAX_LEN-1:0] wdata;
  logic               busy;
  logic               done;
  logic [MAX_LEN-1:0] rdata;
  logic               select;
  logic               capture_en;
  logic               shift_en;
  logic               update_en;
  logic               si;
  logic               so;

  modport slave (
    input  start, len, do_update, run_cycles, wdata, so,
    output busy, done, rdata, select, capture_en, shift_en, update_en, si
  );

  modport master (
    output start, len, do_update, run_cycles, wdata, so,
    input  busy, done, rdata, select, capture_en, shift_en, update_en, si
  );
endinterface

// File: rtl/pmbist_scan_driver.sv
// Sequences one capture -> shift -> update -> run-wait pass on the pmbist serial
// access port from a parallel host command; returns the shifted-out chain in parallel.
//
// state   | meaning
// IDLE    | waiting for start; command inputs latched on the start edge
// CAPTURE | one cycle, select + capture_en
// SHIFT   | len cycles, select + shift_en, si = wdata[i], rdata[i] <= so
// UPDATE  | one cycle, select + update_en (only when do_update)
// RUN     | run_cycles quiet cycles for the BIST engine, down-counter
// DONE    | one-cycle done pulse, busy low
module pmbist_scan_driver #(
  parameter int MAX_LEN = 512,
  parameter int LEN_W   = 10,
  parameter int RUN_W   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  pmbist_scan_driver_if.slave   bus
);

  localparam int              IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    RUN     = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             st, st_nxt, after_shift, after_update;
  logic [LEN_W-1:0]   len_l, cnt, cnt_nxt;
  logic [RUN_W-1:0]   run_cnt, run_nxt;
  logic               upd_l;
  logic [MAX_LEN-1:0] wdata_l;
  logic               take;
  logic               sel_n, cap_n, shf_n, upd_n, si_n, busy_n, done_n;

  always_ff @(posedge clk) begin
    if (!rstn) st <= IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    take         = (st == IDLE) && bus.start;
    after_update = (run_cnt != '0) ? RUN : DONE;
    after_shift  = upd_l ? UPDATE : after_update;
    st_nxt       = st;
    cnt_nxt      = cnt;
    run_nxt      = run_cnt;

    case (st)
      IDLE: begin
        if (bus.start) begin
          st_nxt  = CAPTURE;
          cnt_nxt = '0;
          run_nxt = bus.run_cycles;
        end
      end
      CAPTURE: st_nxt = (len_l != '0) ? SHIFT : after_shift;
      SHIFT: begin
        if (cnt == len_l - LEN_W'(1)) st_nxt = after_shift;
        else                          cnt_nxt = cnt + LEN_W'(1);
      end
      UPDATE: st_nxt = after_update;
      RUN: begin
        run_nxt = run_cnt - RUN_W'(1);
        if (run_cnt == RUN_W'(1)) st_nxt = DONE;
      end
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered pins line up with it.
    cap_n  = (st_nxt == CAPTURE);
    shf_n  = (st_nxt == SHIFT);
    upd_n  = (st_nxt == UPDATE);
    sel_n  = cap_n | shf_n | upd_n;
    si_n   = shf_n & wdata_l[cnt_nxt[IDX_W-1:0]];
    busy_n = cap_n | shf_n | upd_n | (st_nxt == RUN);
    done_n = (st_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt            <= '0;
      run_cnt        <= '0;
      len_l          <= '0;
      upd_l          <= 1'b0;
      wdata_l        <= '0;
      bus.rdata      <= '0;
      bus.select     <= 1'b0;
      bus.capture_en <= 1'b0;
      bus.shift_en   <= 1'b0;
      bus.update_en  <= 1'b0;
      bus.si         <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      run_cnt        <= run_nxt;
      bus.select     <= sel_n;
      bus.capture_en <= cap_n;
      bus.shift_en   <= shf_n;
      bus.update_en  <= upd_n;
      bus.si         <= si_n;
      bus.busy       <= busy_n;
      bus.done       <= done_n;
      if (take) begin
        len_l     <= (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
        upd_l     <= bus.do_update;
        wdata_l   <= bus.wdata;
        bus.rdata <= '0;
      end else if (st == SHIFT) begin
        // so still holds the bit before pmbist_top shifts on this same edge.
        bus.rdata[cnt[IDX_W-1:0]] <= bus.so;
      end
    end
  end

endmodule

// File: tb/tb_pmbist_scan_driver.sv
// Self-checking bench for pmbist_scan_driver: per-cycle pin sequence and returned
// chain data are predicted from the command alone (phase arithmetic on cycle index).
module tb_pmbist_scan_driver;
  localparam int MAX_LEN = 512;
  localparam int LEN_W   = 10;
  localparam int RUN_W   = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pmbist_scan_driver_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .RUN_W(RUN_W)) bus ();

  pmbist_scan_driver #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .RUN_W(RUN_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  // Chain side: either a one-flop loopback of si or bench-chosen so bits.
  logic lb_mode = 1'b0;
  logic so_drv  = 1'b0;
  logic si_d    = 1'b0;
  always @(posedge clk) si_d <= bus.si;
  assign bus.so = lb_mode ? si_d : so_drv;

  int checks = 0;
  int errors = 0;
  int seq_id = 0;

  task automatic check_val(input string tag, input logic [MAX_LEN-1:0] got,
                           input logic [MAX_LEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MAX_LEN-1:0] rand_wide();
    logic [MAX_LEN-1:0] v;
    for (int i = 0; i < MAX_LEN / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [MAX_LEN-1:0] mask_of(input int n);
    logic [MAX_LEN-1:0] m = '0;
    for (int i = 0; i < n && i < MAX_LEN; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [6:0] pins();
    return {bus.select, bus.capture_en, bus.shift_en, bus.update_en,
            bus.si, bus.busy, bus.done};
  endfunction

  task automatic scramble_cmd();
    bus.len        = LEN_W'($urandom);
    bus.do_update  = 1'($urandom);
    bus.run_cycles = RUN_W'($urandom);
    bus.wdata      = rand_wide();
  endtask

  // Runs one command starting at a negedge; returns at the negedge of the idle cycle after done.
  task automatic run_seq(input int len, input bit upd, input int run,
                         input logic [MAX_LEN-1:0] wd, input bit lb,
                         input bit hold, input bit poke);
    int L, B;
    logic [MAX_LEN-1:0] sob, exp_r;
    logic [6:0] exp_p;
    bit cap, shf, updc;
    L   = (len > MAX_LEN) ? MAX_LEN : len;
    B   = 1 + L + int'(upd) + run;
    sob = rand_wide();
    lb_mode        = lb;
    bus.start      = 1'b1;
    bus.len        = LEN_W'(len);
    bus.do_update  = upd;
    bus.run_cycles = RUN_W'(run);
    bus.wdata      = wd;
    seq_id++;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    scramble_cmd();
    exp_r = lb ? ((wd << 1) & mask_of(L)) : (sob & mask_of(L));
    for (int k = 0; k <= B; k++) begin
      @(negedge clk);
      if (poke && !hold) bus.start = (k == 3) || (k == B);
      so_drv = (k >= 1 && k <= L) ? sob[k-1] : 1'($urandom);
      cap   = (k == 0);
      shf   = (k >= 1) && (k <= L);
      updc  = upd && (k == L + 1);
      exp_p = {cap | shf | updc, cap, shf, updc,
               shf ? wd[k-1] : 1'b0, k < B, k == B};
      check_val($sformatf("seq%0d cyc%0d pins", seq_id, k), MAX_LEN'(pins()), MAX_LEN'(exp_p));
      if (k == 0) check_val($sformatf("seq%0d rdata_clr", seq_id), bus.rdata, '0);
      if (k == B) check_val($sformatf("seq%0d rdata", seq_id), bus.rdata, exp_r);
    end
    @(negedge clk);
    if (poke && !hold) bus.start = 1'b0;
    check_val($sformatf("seq%0d idle pins", seq_id), MAX_LEN'(pins()), '0);
    check_val($sformatf("seq%0d rdata_hold", seq_id), bus.rdata, exp_r);
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val($sformatf("%s idle%0d", tag, i), MAX_LEN'(pins()), '0);
    end
  endtask

  initial begin
    logic [MAX_LEN-1:0] wd;
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.do_update  = 1'b0;
    bus.run_cycles = '0;
    bus.wdata      = '0;
    repeat (3) @(negedge clk);
    check_val("reset pins", MAX_LEN'(pins()), '0);
    check_val("reset rdata", bus.rdata, '0);
    rstn = 1'b1;
    @(negedge clk);

    // Setup load: si = 1,1,1,0,0,0 then update, 210 run cycles, busy 218.
    wd = '0; wd[2:0] = 3'b111;
    run_seq(6, 1'b1, 210, wd, 1'b0, 1'b0, 1'b0);

    // Loopback, len 472, wdata bits 4 and 5.
    wd = '0; wd[5:4] = 2'b11;
    run_seq(472, 1'b0, 3, wd, 1'b1, 1'b0, 1'b0);
    check_val("loopback bits", bus.rdata, MAX_LEN'(7'b1100000));

    // Minimal sequence and clamp to MAX_LEN.
    run_seq(0, 1'b0, 0, rand_wide(), 1'b0, 1'b0, 1'b0);
    run_seq(600, 1'b1, 2, rand_wide(), 1'b0, 1'b0, 1'b0);
    run_seq(512, 1'b0, 0, rand_wide(), 1'b1, 1'b0, 1'b0);

    // Start pulsed during SHIFT and DONE: ignored.
    run_seq(8, 1'b1, 1, rand_wide(), 1'b0, 1'b0, 1'b1);
    idle_check(4, "poke");

    // Start held high: sequences follow back to back.
    run_seq(2, 1'b0, 0, rand_wide(), 1'b0, 1'b1, 1'b0);
    run_seq(3, 1'b1, 1, rand_wide(), 1'b1, 1'b1, 1'b0);
    run_seq(1, 1'b0, 2, rand_wide(), 1'b0, 1'b0, 1'b0);
    idle_check(2, "hold_end");

    // Reset in shift cycle 3 of a len=10 run.
    lb_mode        = 1'b0;
    so_drv         = 1'b1;
    bus.start      = 1'b1;
    bus.len        = LEN_W'(10);
    bus.do_update  = 1'b1;
    bus.run_cycles = RUN_W'(5);
    bus.wdata      = rand_wide();
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("pre_reset rdata", bus.rdata, MAX_LEN'(3'b111));
    rstn = 1'b0;
    @(negedge clk);
    check_val("mid_reset pins", MAX_LEN'(pins()), '0);
    check_val("mid_reset rdata", bus.rdata, '0);
    rstn = 1'b1;
    idle_check(4, "post_reset");
    run_seq(10, 1'b1, 2, rand_wide(), 1'b0, 1'b0, 1'b0);

    // Randomised commands.
    for (int n = 0; n < 10; n++) begin
      run_seq($urandom_range(0, 540), 1'($urandom), $urandom_range(0, 30),
              rand_wide(), 1'($urandom), 1'b0, 1'b0);
    end

    // Full-scale run counter.
    run_seq(0, 1'b0, (1 << RUN_W) - 1, rand_wide(), 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
